layer_fetch_scheduler: RTL

- Top-level sequencer for the 4-unit neural datapath. For each layer, in order, it:
  - streams that layer's weights from the single-port weight block RAM into the four NeuralUnits, compensating for the RAM read latency;
  - pulses the sum trigger;
  - waits for the AND-combined unit-done flag;
  - commands the data register bank to capture unit outputs.
- Replaces the separate network controller / RAM read driver pair with one pipelined FSM.

---
 rtl/layer_fetch_scheduler_if.sv | 28 ++
 rtl/layer_fetch_scheduler.sv | 120 ++++++++++++
 2 files changed

// File: rtl/layer_fetch_scheduler_if.sv
// layer_fetch_scheduler_if: scheduler <-> neural datapath signals (weight RAM, unit strobes, layer control).
interface layer_fetch_scheduler_if #(
    parameter int ADDR_W = 7,
    parameter int US_W   = 2,
    parameter int IN_W   = 2
);
    logic              units_done;
    logic [ADDR_W-1:0] ram_addr;
    logic              weight_wr;
    logic [US_W-1:0]   unit_sel;
    logic [IN_W-1:0]   unit_address;
    logic              sum_trigger;
    logic [1:0]        layer;
    logic              layer_sel;
    logic              write_all;

    modport master (
        input  units_done,
        output ram_addr, weight_wr, unit_sel, unit_address,
        output sum_trigger, layer, layer_sel, write_all
    );

    modport slave (
        output units_done,
        input  ram_addr, weight_wr, unit_sel, unit_address,
        input  sum_trigger, layer, layer_sel, write_all
    );
endinterface

// File: rtl/layer_fetch_scheduler.sv
// layer_fetch_scheduler: per-layer weight fetch / sum / wait / write-back sequencer for the neural units.
// Optional LAYER_WATCHDOG_EN bounds WAIT to TIMEOUT cycles and raises a sticky timeout_err.
module layer_fetch_scheduler #(
    parameter int NUM_LAYERS = 3,
    parameter int NUM_UNITS  = 4,
    parameter int NUM_INPUTS = 4,
    parameter int ADDR_W     = 7,
    parameter int RAM_LAT    = 1,
    parameter int TIMEOUT    = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic busy,
    output logic done,
    output logic timeout_err,
    layer_fetch_scheduler_if.master dp
);
    localparam int US_W   = $clog2(NUM_UNITS);
    localparam int IN_W   = $clog2(NUM_INPUTS);
    localparam int CNT_W  = US_W + IN_W;
    localparam int TAG_W  = 1 + CNT_W;
    localparam int PIPE_W = RAM_LAT * TAG_W;
    localparam logic [CNT_W-1:0] LAST_ISSUE = CNT_W'(NUM_UNITS * NUM_INPUTS - 1);
    localparam logic [CNT_W-1:0] LAST_DRAIN = CNT_W'(RAM_LAT - 1);
    localparam logic [1:0]       LAST_LAYER = 2'(NUM_LAYERS - 1);
    localparam logic [31:0]      PER_LAYER  = 32'(NUM_UNITS * NUM_INPUTS);

    typedef enum logic [2:0] {IDLE, FETCH, DRAIN, SUM, WAIT, WB, DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        layer_q, layer_d;
    logic [PIPE_W-1:0] pipe_q, pipe_d;
    logic [TAG_W-1:0]  tag;
    logic              tmo;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start ? FETCH : IDLE;
            FETCH:   state_d = cnt_q == LAST_ISSUE ? DRAIN : FETCH;
            DRAIN:   state_d = cnt_q == LAST_DRAIN ? SUM : DRAIN;
            SUM:     state_d = WAIT;
            WAIT:    state_d = dp.units_done ? WB : (tmo ? DONE : WAIT);
            WB:      state_d = layer_q == LAST_LAYER ? DONE : FETCH;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // cnt is {unit, input} while fetching and the drain cycle count while draining
    always_comb begin
        cnt_d   = (state_d != state_q || !(state_q == FETCH || state_q == DRAIN)) ? '0 : cnt_q + 1'b1;
        layer_d = (state_q == IDLE && start) ? 2'd0
                : ((state_q == WB && state_d == FETCH) ? layer_q + 2'd1 : layer_q);
        tag     = state_q == FETCH ? {1'b1, cnt_q} : '0;
        pipe_d  = PIPE_W'({pipe_q, tag});
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            layer_q <= '0;
            pipe_q  <= '0;
        end else begin
            cnt_q   <= cnt_d;
            layer_q <= layer_d;
            pipe_q  <= pipe_d;
        end
    end

    // oldest pipeline stage sits in the top bits and lines up with the RAM read data
    always_comb begin
        dp.ram_addr    = state_q == FETCH ? ADDR_W'(32'(layer_q) * PER_LAYER + 32'(cnt_q)) : '0;
        dp.weight_wr   = pipe_q[PIPE_W-1];
        {dp.unit_sel, dp.unit_address} = pipe_q[PIPE_W-2 -: CNT_W];
        dp.sum_trigger = state_q == SUM;
        dp.write_all   = state_q == WB;
        dp.layer       = layer_q;
        dp.layer_sel   = state_q != IDLE && layer_q != 2'd0;
        busy           = state_q != IDLE;
        done           = state_q == DONE;
    end

`ifdef LAYER_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wd_q, wd_d;
    logic            err_q, err_d;

    assign tmo = state_q == WAIT && !dp.units_done && wd_q == WD_W'(TIMEOUT - 1);

    always_comb begin
        wd_d  = state_q == WAIT ? wd_q + 1'b1 : '0;
        err_d = (state_q == IDLE && start) ? 1'b0 : (tmo ? 1'b1 : err_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            err_q <= err_d;
        end
    end

    assign timeout_err = err_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign tmo            = 1'b0;
    assign timeout_err    = 1'b0;
`endif
endmodule
